// File: rtl/accum_sched_pkg.sv
// Shared types and constants for the accumulator scheduler.
package accum_sched_pkg;

   typedef enum logic [1:0] {IDLE, SWITCH, FEED, DRAIN} sched_state_t;

   localparam logic CLKSEL_CLK1 = 1'b0;
   localparam logic CLKSEL_CLK2 = 1'b1;

endpackage

// File: rtl/accum_sched_rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer only moves on an explicit update.
module rr_arb2 (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   input  logic update,
   input  logic served,
   output logic gnt
);

   logic prio;

   always_ff @(posedge clk) begin
      if (!reset) begin
         prio <= 1'b0;
      end else if (update) begin
         prio <= ~served;
      end
   end

   // A lone requester always wins; the pointer only breaks ties.
   always_comb begin
      gnt = prio;
      if (req0 && !req1) begin
         gnt = 1'b0;
      end else if (req1 && !req0) begin
         gnt = 1'b1;
      end
   end

endmodule

// File: rtl/accum_sched.sv
// Shares one clock-switched accumulator between two requesters: arbitrate,
// select the grantee's clock, stream a fixed-size burst, return the sum.
module accum_sched
   import accum_sched_pkg::*;
#(
   parameter int   p_width = 4,
   parameter int   p_nmsgs = 4,
   parameter logic p_clk0  = CLKSEL_CLK1,
   parameter logic p_clk1  = CLKSEL_CLK2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in0_val,
   output logic               in0_rdy,
   input  logic [p_width-1:0] in0_msg,
   input  logic               in1_val,
   output logic               in1_rdy,
   input  logic [p_width-1:0] in1_msg,
   output logic               out0_val,
   input  logic               out0_rdy,
   output logic [p_width-1:0] out0_msg,
   output logic               out1_val,
   input  logic               out1_rdy,
   output logic [p_width-1:0] out1_msg,
   output logic               clksel_val,
   input  logic               clksel_rdy,
   output logic               clksel_msg,
   output logic               acc_req_val,
   input  logic               acc_req_rdy,
   output logic [p_width-1:0] acc_req_msg,
   input  logic               acc_resp_val,
   output logic               acc_resp_rdy,
   input  logic [p_width-1:0] acc_resp_msg,
   output logic               grant,
   output logic               busy
);

   localparam int CW = $clog2(p_nmsgs + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(p_nmsgs - 1);

   sched_state_t      state, state_nxt;
   logic [CW-1:0]     cnt;
   logic              grant_q, cur_sel, cur_vld;
   logic              arb_gnt, arb_sel, g_sel;
   logic              g_in_val, g_out_rdy;
   logic [p_width-1:0] g_in_msg;
   logic              sw_xfer, req_xfer, resp_xfer;

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req0   (in0_val),
      .req1   (in1_val),
      .update (resp_xfer),
      .served (grant_q),
      .gnt    (arb_gnt)
   );

   assign arb_sel   = arb_gnt ? p_clk1 : p_clk0;
   assign g_sel     = grant_q ? p_clk1 : p_clk0;
   assign g_in_val  = grant_q ? in1_val : in0_val;
   assign g_in_msg  = grant_q ? in1_msg : in0_msg;
   assign g_out_rdy = grant_q ? out1_rdy : out0_rdy;

   // Transfer strobes are built from inputs and state only, never from the muxed outputs.
   assign sw_xfer   = (state == SWITCH) && clksel_rdy;
   assign req_xfer  = (state == FEED) && g_in_val && acc_req_rdy;
   assign resp_xfer = (state == DRAIN) && acc_resp_val && g_out_rdy;

   assign busy  = (state != IDLE);
   assign grant = grant_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         grant_q <= 1'b0;
         cur_sel <= CLKSEL_CLK1;
         cur_vld <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && (in0_val || in1_val)) begin
            grant_q <= arb_gnt;
         end
         if (sw_xfer) begin
            cur_sel <= g_sel;
            cur_vld <= 1'b1;
         end
         if (req_xfer) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      in0_rdy      = 1'b0;
      in1_rdy      = 1'b0;
      out0_val     = 1'b0;
      out0_msg     = '0;
      out1_val     = 1'b0;
      out1_msg     = '0;
      clksel_val   = 1'b0;
      clksel_msg   = 1'b0;
      acc_req_val  = 1'b0;
      acc_req_msg  = '0;
      acc_resp_rdy = 1'b0;
      case (state)
         IDLE: begin
            // Skip the switch message when the accumulator already runs on the right clock.
            if (in0_val || in1_val) begin
               state_nxt = (cur_vld && arb_sel == cur_sel) ? FEED : SWITCH;
            end
         end
         SWITCH: begin
            clksel_val = 1'b1;
            clksel_msg = g_sel;
            if (sw_xfer) state_nxt = FEED;
         end
         FEED: begin
            acc_req_val = g_in_val;
            acc_req_msg = g_in_val ? g_in_msg : '0;
            if (grant_q) in1_rdy = acc_req_rdy;
            else         in0_rdy = acc_req_rdy;
            if (req_xfer && cnt == CNT_LAST) state_nxt = DRAIN;
         end
         DRAIN: begin
            acc_resp_rdy = g_out_rdy;
            if (grant_q) begin
               out1_val = acc_resp_val;
               out1_msg = acc_resp_val ? acc_resp_msg : '0;
            end else begin
               out0_val = acc_resp_val;
               out0_msg = acc_resp_val ? acc_resp_msg : '0;
            end
            if (resp_xfer) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_accum_sched.sv
// Bench for accum_sched: behavioural 4-operand mod-256 accumulator, table of
// single-requester bursts, then contention, backpressure and mid-burst reset.
module tb_accum_sched;

   localparam int W = 8;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         in0_val, in0_rdy, in1_val, in1_rdy;
   logic [W-1:0] in0_msg, in1_msg;
   logic         out0_val, out0_rdy, out1_val, out1_rdy;
   logic [W-1:0] out0_msg, out1_msg;
   logic         clksel_val, clksel_rdy, clksel_msg;
   logic         acc_req_val, acc_req_rdy, acc_resp_val, acc_resp_rdy;
   logic [W-1:0] acc_req_msg, acc_resp_msg;
   logic         grant, busy;

   always #5 clk = ~clk;

   accum_sched #(.p_width(W), .p_nmsgs(N), .p_clk0(1'b0), .p_clk1(1'b1)) dut (
      .clk(clk), .reset(reset),
      .in0_val(in0_val), .in0_rdy(in0_rdy), .in0_msg(in0_msg),
      .in1_val(in1_val), .in1_rdy(in1_rdy), .in1_msg(in1_msg),
      .out0_val(out0_val), .out0_rdy(out0_rdy), .out0_msg(out0_msg),
      .out1_val(out1_val), .out1_rdy(out1_rdy), .out1_msg(out1_msg),
      .clksel_val(clksel_val), .clksel_rdy(clksel_rdy), .clksel_msg(clksel_msg),
      .acc_req_val(acc_req_val), .acc_req_rdy(acc_req_rdy), .acc_req_msg(acc_req_msg),
      .acc_resp_val(acc_resp_val), .acc_resp_rdy(acc_resp_rdy), .acc_resp_msg(acc_resp_msg),
      .grant(grant), .busy(busy)
   );

   typedef struct {
      int             id;
      logic [4*W-1:0] ops;
      int             n_sel;
      int             sel;
      int             sum;
   } vec_t;

   int checks = 0;
   int failures = 0;

   int sel_q[$];
   int req_q[$];
   int res_id_q[$];
   int res_val_q[$];
   int o_val_seen[2];
   int busy_drops = 0;
   bit track_busy = 1'b0;
   bit acc_toggle = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [4*W-1:0] pack4(input int a, input int b, input int c, input int d);
      logic [W-1:0] wa, wb, wc, wd;
      wa = W'(a); wb = W'(b); wc = W'(c); wd = W'(d);
      return {wd, wc, wb, wa};
   endfunction

   function automatic logic [4*W-1:0] req_word();
      logic [4*W-1:0] w;
      int             v;
      w = '0;
      for (int k = 0; k < req_q.size() && k < 4; k++) begin
         v = req_q[k];
         w[k*W +: W] = v[W-1:0];
      end
      return w;
   endfunction

   task automatic clear_logs();
      sel_q.delete();
      req_q.delete();
      res_id_q.delete();
      res_val_q.delete();
      o_val_seen[0] = 0;
      o_val_seen[1] = 0;
   endtask

   task automatic set_in(input int id, input logic v, input logic [W-1:0] m);
      if (id == 0) begin
         in0_val = v;
         in0_msg = v ? m : '0;
      end else begin
         in1_val = v;
         in1_msg = v ? m : '0;
      end
   endtask

   // Offers cnt operands on requester id, holding each until accepted.
   task automatic drive(input int id, input logic [4*W-1:0] ops, input int cnt);
      bit done;
      for (int k = 0; k < cnt; k++) begin
         done = 1'b0;
         set_in(id, 1'b1, ops[k*W +: W]);
         for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = (id == 0) ? (in0_rdy === 1'b1) : (in1_rdy === 1'b1);
            @(posedge clk); #1;
         end
         check($sformatf("in%0d_accept_op%0d", id, k), done, 1);
      end
      set_in(id, 1'b0, '0);
   endtask

   task automatic get_result(output int id, output int val);
      int t;
      t = 0;
      id = -1;
      val = -1;
      while (res_id_q.size() == 0 && t < 300) begin
         @(posedge clk); #2;
         t++;
      end
      if (res_id_q.size() > 0) begin
         id  = res_id_q.pop_front();
         val = res_val_q.pop_front();
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      set_in(0, 1'b0, '0);
      set_in(1, 1'b0, '0);
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b1;
      clear_logs();
   endtask

   // Behavioural accumulator plus transfer logger; samples on negedge, updates after posedge.
   initial begin
      bit           rx, sx, rst_now;
      logic [W-1:0] rmsg;
      int           acc_sum, acc_n;
      acc_req_rdy  = 1'b1;
      acc_resp_val = 1'b0;
      acc_resp_msg = '0;
      acc_sum = 0;
      acc_n   = 0;
      forever begin
         @(negedge clk);
         rx   = acc_req_val && acc_req_rdy;
         rmsg = acc_req_msg;
         sx   = acc_resp_val && acc_resp_rdy;
         rst_now = !reset;
         if (track_busy && !busy) busy_drops++;
         if (clksel_val && clksel_rdy) sel_q.push_back(int'(clksel_msg));
         if (rx) req_q.push_back(int'(rmsg));
         if (out0_val) o_val_seen[0]++;
         if (out1_val) o_val_seen[1]++;
         if (out0_val && out0_rdy) begin
            res_id_q.push_back(0);
            res_val_q.push_back(int'(out0_msg));
            track_busy = 1'b0;
         end
         if (out1_val && out1_rdy) begin
            res_id_q.push_back(1);
            res_val_q.push_back(int'(out1_msg));
            track_busy = 1'b0;
         end
         @(posedge clk); #1;
         if (rst_now) begin
            acc_sum = 0;
            acc_n   = 0;
            acc_resp_val = 1'b0;
            acc_resp_msg = '0;
         end else begin
            if (sx) begin
               acc_resp_val = 1'b0;
               acc_resp_msg = '0;
            end
            if (rx) begin
               acc_sum = (acc_sum + int'(rmsg)) % 256;
               acc_n++;
               if (acc_n == N) begin
                  acc_resp_val = 1'b1;
                  acc_resp_msg = acc_sum[W-1:0];
                  acc_sum = 0;
                  acc_n   = 0;
               end
            end
         end
         acc_req_rdy = acc_toggle ? ~acc_req_rdy : 1'b1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

   initial begin
      vec_t vt[6];
      int   rid, rv;

      vt[0] = '{0, pack4(1, 2, 3, 4),       1, 0, 10};
      vt[1] = '{0, pack4(5, 5, 5, 5),       0, 0, 20};
      vt[2] = '{1, pack4(10, 20, 30, 40),   1, 1, 100};
      vt[3] = '{0, pack4(200, 100, 0, 0),   1, 0, 44};
      vt[4] = '{0, pack4(7, 8, 9, 10),      0, 0, 34};
      vt[5] = '{1, pack4(255, 1, 2, 3),     1, 1, 5};

      reset      = 1'b0;
      clksel_rdy = 1'b1;
      out0_rdy   = 1'b1;
      out1_rdy   = 1'b1;
      set_in(0, 1'b1, 8'h11);
      set_in(1, 1'b1, 8'h22);
      repeat (3) begin @(posedge clk); #1; end
      check("reset_ctrl", {busy, grant, in0_rdy, in1_rdy, out0_val, out1_val,
                           clksel_val, acc_req_val, acc_resp_rdy}, 0);
      check("reset_msgs", {out0_msg, out1_msg, clksel_msg, acc_req_msg}, 0);
      set_in(0, 1'b0, '0);
      set_in(1, 1'b0, '0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("idle_no_req_busy", busy, 0);
      clear_logs();

      for (int i = 0; i < 6; i++) begin
         clear_logs();
         drive(vt[i].id, vt[i].ops, N);
         get_result(rid, rv);
         check($sformatf("v%0d_res_id", i), rid, vt[i].id);
         check($sformatf("v%0d_sum", i), rv, vt[i].sum);
         check($sformatf("v%0d_nsel", i), sel_q.size(), vt[i].n_sel);
         if (vt[i].n_sel > 0 && sel_q.size() > 0)
            check($sformatf("v%0d_selmsg", i), sel_q[0], vt[i].sel);
         check($sformatf("v%0d_nreq", i), req_q.size(), N);
         check($sformatf("v%0d_reqseq", i), req_word(), vt[i].ops);
         check($sformatf("v%0d_other_out", i), o_val_seen[1 - vt[i].id], 0);
         check($sformatf("v%0d_grant", i), grant, vt[i].id);
         check($sformatf("v%0d_busy_after", i), busy, 0);
      end

      // Contention straight after reset: in0 first, then in1, then in0 again.
      do_reset();
      fork
         drive(0, pack4(1, 1, 1, 1), N);
         drive(1, pack4(10, 20, 30, 40), N);
      join
      get_result(rid, rv);
      check("cont1_first_id", rid, 0);
      check("cont1_first_sum", rv, 4);
      get_result(rid, rv);
      check("cont1_second_id", rid, 1);
      check("cont1_second_sum", rv, 100);
      check("cont1_nsel", sel_q.size(), 2);
      if (sel_q.size() == 2) begin
         check("cont1_sel0", sel_q[0], 0);
         check("cont1_sel1", sel_q[1], 1);
      end
      clear_logs();
      fork
         drive(0, pack4(2, 2, 2, 2), N);
         drive(1, pack4(3, 3, 3, 3), N);
      join
      get_result(rid, rv);
      check("cont2_first_id", rid, 0);
      check("cont2_first_sum", rv, 8);
      get_result(rid, rv);
      check("cont2_second_id", rid, 1);
      check("cont2_second_sum", rv, 12);

      // Backpressure on every handshake.
      do_reset();
      busy_drops = 0;
      clksel_rdy = 1'b0;
      out0_rdy   = 1'b0;
      acc_toggle = 1'b1;
      fork
         drive(0, pack4(3, 7, 11, 13), N);
         begin
            @(posedge clk); #1;
            track_busy = 1'b1;
            repeat (3) begin @(posedge clk); #1; end
            clksel_rdy = 1'b1;
            for (int t = 0; t < 200 && !out0_val; t++) begin @(posedge clk); #1; end
            repeat (5) begin @(posedge clk); #1; end
            out0_rdy = 1'b1;
         end
      join
      get_result(rid, rv);
      acc_toggle = 1'b0;
      check("bp_id", rid, 0);
      check("bp_sum", rv, 34);
      check("bp_reqseq", req_word(), pack4(3, 7, 11, 13));
      check("bp_nreq", req_q.size(), N);
      check("bp_nsel", sel_q.size(), 1);
      check("bp_busy_drops", busy_drops, 0);
      check("bp_out0_held", o_val_seen[0] >= 6, 1);
      check("bp_other_out", o_val_seen[1], 0);

      // Reset after two of four operands.
      do_reset();
      drive(0, pack4(9, 9, 9, 9), 2);
      check("mid_nreq", req_q.size(), 2);
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      check("mid_reset_ctrl", {busy, in0_rdy, in1_rdy, out0_val, out1_val,
                               clksel_val, acc_req_val, acc_resp_rdy}, 0);
      clear_logs();
      drive(0, pack4(1, 1, 1, 1), N);
      get_result(rid, rv);
      check("mid_after_id", rid, 0);
      check("mid_after_sum", rv, 4);
      check("mid_after_nsel", sel_q.size(), 1);
      if (sel_q.size() > 0) check("mid_after_selmsg", sel_q[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/accum_sched.md
# accum_sched

Scheduler that shares one clock-switched accumulator (accum plus ClockSwitcher) between two requesters. It sits in front of the accumulator tile in the mac-rgals datapath and arbitrates round-robin between requesters. Before each burst it sends a clock-select message to the switcher so the accumulator runs on the requester's preferred clock. It then streams exactly `p_nmsgs` operands into the accumulator and routes the single resulting sum back to the granted requester.

## Interface
**Parameters**
- `p_width`, 4, operand/result width in bits.
- `p_nmsgs`, 4, operands per burst; must be ≥1. This equals the accumulator's operands-per-result.
- `p_clk0`, 0, clksel message for requester 0 (0 = clk1, 1 = clk2).
- `p_clk1`, 1, clksel message for requester 1.

**Ports**
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low: `reset==0` at a rising edge resets all state.
- `in0_val` / `in0_rdy` / `in0_msg`  in / out / in  1 / 1 / `p_width`  requester 0 operand stream.
- `in1_val` / `in1_rdy` / `in1_msg`  in / out / in  1 / 1 / `p_width`  requester 1 operand stream.
- `out0_val` / `out0_rdy` / `out0_msg`  out / in / out  1 / 1 / `p_width`  requester 0 result.
- `out1_val` / `out1_rdy` / `out1_msg`  out / in / out  1 / 1 / `p_width`  requester 1 result.
- `clksel_val` / `clksel_rdy` / `clksel_msg`  out / in / out  1 / 1 / 1  to ClockSwitcher.
- `acc_req_val` / `acc_req_rdy` / `acc_req_msg`  out / in / out  1 / 1 / `p_width`  to accumulator.
- `acc_resp_val` / `acc_resp_rdy` / `acc_resp_msg`  in / out / in  1 / 1 / `p_width`  from accumulator.
- `grant`  out  1  index of the current or last granted requester.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- **Handshakes:** val/rdy; a transfer occurs on a cycle where both are high. A sender holds val and msg stable until the transfer.
- **FSM states:** IDLE, SWITCH, FEED, DRAIN.
- **IDLE**
  - Arbitrate on `in0_val`/`in1_val`.
  - If exactly one is high, grant it.
  - If both are high, grant the requester named by priority pointer `prio`.
  - Register `grant`.
  - If the granted requester's clock equals `cur_sel` and `cur_vld==1`, go to FEED. Otherwise go to SWITCH.
  - No operand is consumed in IDLE; all `in*_rdy` are 0.
- **SWITCH**
  - `clksel_val=1`, `clksel_msg` = the grantee's `p_clkN`.
  - On transfer: set `cur_sel` to that message, set `cur_vld=1`, go to FEED.
- **FEED**
  - Combinational pass-through from the grantee: `acc_req_val=inG_val`, `inG_rdy=acc_req_rdy`, `acc_req_msg=inG_msg`.
  - The non-granted `in*_rdy` is 0.
  - Counter `cnt` (width `$clog2(p_nmsgs+1)`) increments on each transfer.
  - On the transfer that makes `cnt==p_nmsgs`: clear `cnt`, go to DRAIN.
- **DRAIN**
  - `outG_val=acc_resp_val`, `acc_resp_rdy=outG_rdy`, `outG_msg=acc_resp_msg`.
  - The other `out*_val` is 0.
  - On transfer: set `prio` to the other requester, go to IDLE.
- Outside DRAIN, `acc_resp_rdy=0` and both `out*_val` are 0.
- Outside FEED, `acc_req_val=0`.
- Messages pass through unmodified; no arithmetic is performed on data.

## Timing
- **Reset values:**
  - State = IDLE, `prio=0`, `cnt=0`, `cur_vld=0`, `cur_sel=0`, `grant=0`.
  - All val and rdy outputs 0, `busy=0`.
  - All msg outputs 0 whenever their val is 0.
- **Overhead per burst:**
  - 1 cycle IDLE arbitration, plus
  - ≥1 cycle SWITCH (skipped when the clock already matches), plus
  - `p_nmsgs` FEED transfers at up to one per cycle, plus
  - ≥1 DRAIN cycle.
- **Back-to-back bursts:** after the DRAIN transfer, the next grant is decided in the following IDLE cycle.
- **Simultaneous requests in IDLE:** `prio` decides the grant. With continuous contention, grants strictly alternate.
- **Mid-burst behaviour:** a requester dropping `val` in FEED stalls the burst. There is no timeout and no preemption.
- **Reset mid-operation:** `reset==0` in any state returns to reset values at that edge.
  - Any partial FEED count is discarded.
  - `cur_vld=0`, so the next burst always performs SWITCH.
  - The accumulator is reset by its own `reset`, driven by the same system reset.
- **Boundary case:** with `p_nmsgs=1`, the FEED-to-DRAIN transition occurs on the first transfer.

## Structure
- Shared package `accum_sched_pkg`:
  - state enum `sched_state_t` {IDLE, SWITCH, FEED, DRAIN};
  - constants `CLKSEL_CLK1=1'b0` and `CLKSEL_CLK2=1'b1`.
- One natural sub-module: `rr_arb2`.
  - Two-input round-robin arbiter with a registered priority pointer.
  - Advanced only by an explicit `update` pulse from the DRAIN-state transfer.
- FSM, counter and mux steering stay in `accum_sched`.

## Test plan
All scenarios use `p_width=8`, `p_nmsgs=4`, with a behavioural accumulator that sums 4 operands modulo 256.
- **Single requester:** in0 sends 1,2,3,4.
  - Expected: one clksel transfer with msg 0, then `acc_req` sees 1,2,3,4, then `out0` gets 10. `out1_val` stays 0 throughout.
- **Clock reuse:** in0 sends a second burst 5,5,5,5 immediately.
  - Expected: no clksel transfer, `out0` gets 20.
- **Contention:** in0 and in1 both assert in the same IDLE cycle after reset.
  - Expected: in0 is granted first. in1's burst 10,20,30,40 follows with clksel msg 1, and `out1` gets 100. Next contention grants in0.
- **Backpressure:** `clksel_rdy` held low 3 cycles, `acc_req_rdy` toggling, `out0_rdy` held low 5 cycles.
  - Expected: no operand lost or duplicated, correct sum delivered, `busy` high throughout.
- **Reset mid-FEED:** `reset=0` after 2 of 4 operands.
  - Expected: state returns to IDLE, all vals 0. The next in0 burst 1,1,1,1 issues clksel again and returns 4.
- **Overflow:** 200,100,0,0.
  - Expected: result 44, passed through unchanged.
